// File: rtl/adder_scheduler_pkg.sv
// Shared types and constants for the nibble-serial adder scheduler.
package adder_sched_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/adder_scheduler_if.sv
// Two operand requesters plus the result channel of the adder scheduler.
interface adder_scheduler_if #(
    parameter int unsigned WIDTH = 16
);
    import adder_sched_pkg::*;

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    req_id_t          res_id;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        input  req0_ready, req1_ready,
        input  res_valid, res_sum, res_cout, res_id,
        output res_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        output req0_ready, req1_ready,
        output res_valid, res_sum, res_cout, res_id,
        input  res_ready
    );

endinterface

// File: rtl/adder_scheduler_adder.sv
// Shared 4-bit ripple datapath used once per clock by the scheduler.
module four_bit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/adder_scheduler.sv
// Round-robin front end that runs WIDTH-bit adds nibble by nibble through one
// shared four_bit_adder, with the carry held in a register between nibbles.
module adder_scheduler
    import adder_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    adder_scheduler_if.slave   bus,
    output logic               busy
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned KW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $error("adder_scheduler: WIDTH must be a non-zero multiple of 4");
    end

    state_t           state, state_next;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
    logic             carry, cout_reg;
    req_id_t          id_reg, rr_ptr, grant_id;
    logic             accept, last_nibble;
    logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
    logic                nib_cout;

    assign last_nibble = (k == KW'(NIBBLES - 1));
    assign nib_a       = a_reg[k*NIBBLE_W +: NIBBLE_W];
    assign nib_b       = b_reg[k*NIBBLE_W +: NIBBLE_W];

    four_bit_adder u_adder (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept)        state_next = ADD;
            ADD:     if (last_nibble)   state_next = DONE;
            DONE:    if (bus.res_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // Ready is masked by reset so no grant is offered while reset is held.
    always_comb begin
        grant_id = 1'b0;
        if (bus.req0_valid && bus.req1_valid) grant_id = rr_ptr;
        else                                  grant_id = bus.req1_valid;
        accept         = (state == IDLE) && !reset && (bus.req0_valid || bus.req1_valid);
        bus.req0_ready = accept && (grant_id == 1'b0);
        bus.req1_ready = accept && (grant_id == 1'b1);
        bus.res_valid  = (state == DONE);
        busy           = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
            id_reg   <= 1'b0;
            rr_ptr   <= 1'b0;
            k        <= '0;
        end else if (accept) begin
            a_reg  <= grant_id ? bus.req1_a   : bus.req0_a;
            b_reg  <= grant_id ? bus.req1_b   : bus.req0_b;
            carry  <= grant_id ? bus.req1_cin : bus.req0_cin;
            id_reg <= grant_id;
            rr_ptr <= ~grant_id;
            k      <= '0;
        end else if (state == ADD) begin
            sum_reg[k*NIBBLE_W +: NIBBLE_W] <= nib_sum;
            carry <= nib_cout;
            // k wraps on the last nibble so it never indexes past the operands.
            k     <= last_nibble ? '0 : k + KW'(1);
            if (last_nibble) cout_reg <= nib_cout;
        end
    end

    assign bus.res_sum  = sum_reg;
    assign bus.res_cout = cout_reg;
    assign bus.res_id   = id_reg;

endmodule

// File: tb/tb_adder_scheduler.sv
// Randomized and directed bench for adder_scheduler at WIDTH=16 and WIDTH=4.
module tb_adder_scheduler;
    import adder_sched_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic busy16, busy4;
    int   checks = 0;
    int   errors = 0;
    bit   model_ptr;
    bit   model_ptr4;

    always #5 clk = ~clk;

    adder_scheduler_if #(.WIDTH(16)) bus16 ();
    adder_scheduler_if #(.WIDTH(4))  bus4 ();

    adder_scheduler #(.WIDTH(16)) u_dut16 (.clk(clk), .reset(reset), .bus(bus16), .busy(busy16));
    adder_scheduler #(.WIDTH(4))  u_dut4  (.clk(clk), .reset(reset), .bus(bus4),  .busy(busy4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus16.req0_valid = 0; bus16.req0_a = '0; bus16.req0_b = '0; bus16.req0_cin = 0;
        bus16.req1_valid = 0; bus16.req1_a = '0; bus16.req1_b = '0; bus16.req1_cin = 0;
        bus16.res_ready  = 0;
        bus4.req0_valid  = 0; bus4.req0_a = '0; bus4.req0_b = '0; bus4.req0_cin = 0;
        bus4.req1_valid  = 0; bus4.req1_a = '0; bus4.req1_b = '0; bus4.req1_cin = 0;
        bus4.res_ready   = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        clear_inputs();
        tick();
        tick();
        reset = 0;
        model_ptr  = 0;
        model_ptr4 = 0;
    endtask

    // Presents requests, waits for a grant, then scrambles the operands so a
    // late change would corrupt the result; drains the result with res_ready.
    task automatic txn16(input bit v0, input bit v1,
                         input logic [15:0] a0, input logic [15:0] b0, input bit c0,
                         input logic [15:0] a1, input logic [15:0] b1, input bit c1,
                         output bit grant, output logic [15:0] s, output bit co,
                         output bit rid, output int lat, output bit timeout);
        timeout = 0; grant = 0; s = '0; co = 0; rid = 0; lat = 0;
        bus16.req0_valid = v0; bus16.req0_a = a0; bus16.req0_b = b0; bus16.req0_cin = c0;
        bus16.req1_valid = v1; bus16.req1_a = a1; bus16.req1_b = b1; bus16.req1_cin = c1;
        bus16.res_ready  = 0;
        #1;
        for (int n = 0; n < 10 && !(bus16.req0_ready || bus16.req1_ready); n++) tick();
        if (!(bus16.req0_ready || bus16.req1_ready)) begin
            timeout = 1;
            clear_inputs();
            return;
        end
        grant = bus16.req1_ready;
        tick();
        bus16.req0_valid = 0; bus16.req1_valid = 0;
        bus16.req0_a = 16'($urandom); bus16.req0_b = 16'($urandom); bus16.req0_cin = 1'($urandom);
        bus16.req1_a = 16'($urandom); bus16.req1_b = 16'($urandom); bus16.req1_cin = 1'($urandom);
        while (!bus16.res_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!bus16.res_valid) timeout = 1;
        s = bus16.res_sum; co = bus16.res_cout; rid = bus16.res_id;
        bus16.res_ready = 1;
        tick();
        bus16.res_ready = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        clear_inputs();
        bus16.req0_valid = 1; bus16.req1_valid = 1;
        tick();
        tick();
        checks++;
        if ((bus16.req0_ready | bus16.req1_ready) !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b%b expected 00", bus16.req0_ready, bus16.req1_ready);
        end
        checks++;
        if ({bus16.res_valid, bus16.res_sum, bus16.res_cout, bus16.res_id, busy16} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b sum=%h cout=%b id=%b busy=%b expected all 0",
                     bus16.res_valid, bus16.res_sum, bus16.res_cout, bus16.res_id, busy16);
        end
        reset = 0;
        clear_inputs();
        model_ptr = 0; model_ptr4 = 0;
        tick();
        checks++;
        if ({bus16.res_valid, busy16, bus4.res_valid, busy4} !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset_idle: valid16=%b busy16=%b valid4=%b busy4=%b expected 0",
                     bus16.res_valid, busy16, bus4.res_valid, busy4);
        end
    endtask

    task automatic test_directed();
        logic [15:0] da [3] = '{16'h1234, 16'hFFFF, 16'hFFFF};
        logic [15:0] db [3] = '{16'h0FFF, 16'h0001, 16'hFFFF};
        bit          dc [3] = '{1'b0, 1'b0, 1'b1};
        bit          di [3] = '{1'b0, 1'b1, 1'b0};
        logic [15:0] es [3] = '{16'h2233, 16'h0000, 16'hFFFF};
        bit          ec [3] = '{1'b0, 1'b1, 1'b1};
        bit g, co, rid, to;
        logic [15:0] s;
        int lat;
        for (int i = 0; i < 3; i++) begin
            txn16(!di[i], di[i], da[i], db[i], dc[i], da[i], db[i], dc[i], g, s, co, rid, lat, to);
            model_ptr = ~di[i];
            checks++;
            if (to || s !== es[i] || co !== ec[i] || rid !== di[i] || g !== di[i]) begin
                errors++;
                $display("FAIL directed_%0d: sum=%h cout=%b id=%b grant=%b timeout=%b expected sum=%h cout=%b id=%b",
                         i, s, co, rid, g, to, es[i], ec[i], di[i]);
            end
            checks++;
            if (lat !== 4) begin
                errors++;
                $display("FAIL directed_latency_%0d: got %0d expected 4", i, lat);
            end
            checks++;
            if (bus16.res_valid !== 1'b0) begin
                errors++;
                $display("FAIL valid_one_cycle_%0d: res_valid=%b expected 0", i, bus16.res_valid);
            end
        end
    endtask

    task automatic test_random();
        bit g, co, rid, to, v0, v1, c0, c1, eg;
        logic [15:0] a0, b0, a1, b1, s;
        logic [16:0] full;
        int lat, sel;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(1, 3);
            v0 = sel[0]; v1 = sel[1];
            a0 = 16'($urandom); b0 = 16'($urandom); c0 = 1'($urandom);
            a1 = 16'($urandom); b1 = 16'($urandom); c1 = 1'($urandom);
            eg = (v0 && v1) ? model_ptr : v1;
            model_ptr = ~eg;
            full = eg ? ({1'b0, a1} + {1'b0, b1} + {16'b0, c1})
                      : ({1'b0, a0} + {1'b0, b0} + {16'b0, c0});
            txn16(v0, v1, a0, b0, c0, a1, b1, c1, g, s, co, rid, lat, to);
            checks++;
            if (to || g !== eg || rid !== eg || s !== full[15:0] || co !== full[16] || lat !== 4) begin
                errors++;
                $display("FAIL random_%0d: grant=%b id=%b sum=%h cout=%b lat=%0d timeout=%b expected grant=%b sum=%h cout=%b lat=4",
                         i, g, rid, s, co, lat, to, eg, full[15:0], full[16]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int   nres = 0;
        int   last_t = -1;
        bit   exp_id;
        do_reset();
        exp_id = 0;
        bus16.req0_valid = 1; bus16.req0_a = 16'd1; bus16.req0_b = 16'd1;
        bus16.req1_valid = 1; bus16.req1_a = 16'd2; bus16.req1_b = 16'd2;
        bus16.res_ready  = 1;
        for (int t = 0; t < 60 && nres < 4; t++) begin
            tick();
            checks++;
            if ((bus16.req0_ready && bus16.req1_ready) || ((bus16.req0_ready || bus16.req1_ready) && busy16)) begin
                errors++;
                $display("FAIL rr_ready_excl: r0=%b r1=%b busy=%b expected at most one ready and only when idle",
                         bus16.req0_ready, bus16.req1_ready, busy16);
            end
            if (bus16.res_valid) begin
                checks++;
                if (bus16.res_id !== exp_id || bus16.res_sum !== (exp_id ? 16'h0004 : 16'h0002)) begin
                    errors++;
                    $display("FAIL rr_order_%0d: id=%b sum=%h expected id=%b sum=%h",
                             nres, bus16.res_id, bus16.res_sum, exp_id, exp_id ? 16'h0004 : 16'h0002);
                end
                if (last_t >= 0) begin
                    checks++;
                    if (t - last_t != 6) begin
                        errors++;
                        $display("FAIL rr_throughput: got %0d cycles expected 6", t - last_t);
                    end
                end
                last_t = t;
                exp_id = ~exp_id;
                nres++;
            end
        end
        checks++;
        if (nres != 4) begin
            errors++;
            $display("FAIL rr_result_count: got %0d expected 4", nres);
        end
        do_reset();
    endtask

    task automatic test_backpressure();
        logic [15:0] a, b, s;
        logic [16:0] full;
        int lat = 0;
        a = 16'($urandom); b = 16'($urandom);
        full = {1'b0, a} + {1'b0, b};
        bus16.req0_valid = 1; bus16.req0_a = a; bus16.req0_b = b; bus16.req0_cin = 0;
        #1;
        checks++;
        if (bus16.req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_grant: req0_ready=%b expected 1", bus16.req0_ready);
        end
        tick();
        model_ptr = 1;
        bus16.req0_a = 16'($urandom); bus16.req1_valid = 1; bus16.req1_a = 16'($urandom);
        while (!bus16.res_valid && lat < 20) begin tick(); lat++; end
        s = bus16.res_sum;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus16.res_valid !== 1'b1 || bus16.res_sum !== full[15:0] || bus16.res_sum !== s ||
                bus16.res_id !== 1'b0 || bus16.req0_ready !== 1'b0 || bus16.req1_ready !== 1'b0 || busy16 !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold_%0d: valid=%b sum=%h id=%b r0=%b r1=%b busy=%b expected 1 %h 0 0 0 1",
                         i, bus16.res_valid, bus16.res_sum, bus16.res_id, bus16.req0_ready, bus16.req1_ready,
                         busy16, full[15:0]);
            end
            tick();
        end
        bus16.res_ready = 1;
        tick();
        bus16.res_ready = 0;
        checks++;
        if (bus16.res_valid !== 1'b0 || busy16 !== 1'b0 || bus16.req1_ready !== model_ptr || bus16.req0_ready === model_ptr) begin
            errors++;
            $display("FAIL bp_release: valid=%b busy=%b r0=%b r1=%b expected 0 0 and grant to req%0d",
                     bus16.res_valid, busy16, bus16.req0_ready, bus16.req1_ready, model_ptr);
        end
        tick();
        checks++;
        if (busy16 !== 1'b1) begin
            errors++;
            $display("FAIL bp_new_accept: busy=%b expected 1", busy16);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        bit g, co, rid, to;
        logic [15:0] s;
        int lat;
        bus16.req0_valid = 1; bus16.req0_a = 16'hABCD; bus16.req0_b = 16'h1111;
        #1;
        tick();
        bus16.req0_valid = 0;
        tick();
        tick();
        reset = 1;
        bus16.req0_valid = 1; bus16.req1_valid = 1;
        #1;
        checks++;
        if ((bus16.req0_ready | bus16.req1_ready) !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ready: r0=%b r1=%b expected 0", bus16.req0_ready, bus16.req1_ready);
        end
        tick();
        checks++;
        if ({bus16.res_valid, bus16.res_sum, bus16.res_cout, bus16.res_id, busy16} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: valid=%b sum=%h cout=%b id=%b busy=%b expected all 0",
                     bus16.res_valid, bus16.res_sum, bus16.res_cout, bus16.res_id, busy16);
        end
        reset = 0;
        clear_inputs();
        model_ptr = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (bus16.res_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_no_result: res_valid=%b expected 0", bus16.res_valid);
            end
        end
        txn16(0, 1, 16'h0, 16'h0, 0, 16'd5, 16'd6, 0, g, s, co, rid, lat, to);
        model_ptr = 0;
        checks++;
        if (to || g !== 1'b1 || s !== 16'h000B || rid !== 1'b1 || co !== 1'b0) begin
            errors++;
            $display("FAIL midreset_req1: grant=%b sum=%h id=%b cout=%b timeout=%b expected 1 000b 1 0",
                     g, s, rid, co, to);
        end
    endtask

    task automatic test_width4();
        bit id, eg, c;
        logic [3:0] a, b;
        logic [4:0] full;
        int lat;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i == 0) begin
                id = 0; a = 4'hF; b = 4'h1; c = 1;
            end else begin
                id = 1'($urandom); a = 4'($urandom); b = 4'($urandom); c = 1'($urandom);
            end
            eg = id;
            full = {1'b0, a} + {1'b0, b} + {4'b0, c};
            bus4.req0_valid = !id; bus4.req1_valid = id;
            bus4.req0_a = a; bus4.req0_b = b; bus4.req0_cin = c;
            bus4.req1_a = a; bus4.req1_b = b; bus4.req1_cin = c;
            #1;
            checks++;
            if (bus4.req0_ready !== !eg || bus4.req1_ready !== eg) begin
                errors++;
                $display("FAIL w4_grant_%0d: r0=%b r1=%b expected req%0d", i, bus4.req0_ready, bus4.req1_ready, eg);
            end
            tick();
            bus4.req0_valid = 0; bus4.req1_valid = 0; bus4.req0_a = 4'($urandom); bus4.req1_b = 4'($urandom);
            lat = 0;
            while (!bus4.res_valid && lat < 10) begin tick(); lat++; end
            checks++;
            if (lat !== 1 || bus4.res_sum !== full[3:0] || bus4.res_cout !== full[4] || bus4.res_id !== eg) begin
                errors++;
                $display("FAIL w4_result_%0d: lat=%0d sum=%h cout=%b id=%b expected lat=1 sum=%h cout=%b id=%b",
                         i, lat, bus4.res_sum, bus4.res_cout, bus4.res_id, full[3:0], full[4], eg);
            end
            bus4.res_ready = 1;
            tick();
            bus4.res_ready = 0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_width4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
